// File: rtl/tdm_serializer_if.sv
// Frame-side handshake between a frame producer and the TDM serializer:
// five channel words offered with frame_valid, accepted when frame_ready is high.
interface tdm_serializer_if;
  logic [31:0] ch0;
  logic [31:0] ch1;
  logic [31:0] ch2;
  logic [31:0] ch3;
  logic [31:0] ch4;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output ch0, ch1, ch2, ch3, ch4, frame_valid,
    input  frame_ready
  );

  modport slave (
    input  ch0, ch1, ch2, ch3, ch4, frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/tdm_serializer.sv
// Five-channel TDM serializer: one sync cycle, then 5*SLOT_BITS data bits MSB first,
// with a one-frame holding buffer so a new frame can queue while the current one shifts out.
module tdm_serializer #(
  parameter int SLOT_BITS  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic             tdm_clk,
  input  logic             reset,
  tdm_serializer_if.slave  frame,
  output logic             tdm_sync,
  output logic             tdm_data,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam int         FRAME_BITS = 5 * SLOT_BITS;
  localparam logic [6:0] LAST_BIT   = 7'(FRAME_BITS - 1);
  localparam logic [7:0] LAST_GAP   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [FRAME_BITS-1:0]   hold_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic                    hold_full_r;
  logic [6:0]              bit_cnt_r;
  logic [7:0]              gap_cnt_r;
  logic                    sync_r;
  logic                    data_r;
  logic                    busy_r;
  logic                    done_r;
  logic [7:0]              count_r;
  logic                    accept_s;
  logic                    load_s;
  logic                    last_bit_s;
  logic                    last_gap_s;

  assign frame.frame_ready = ~hold_full_r;
  assign accept_s          = frame.frame_valid & ~hold_full_r;
  assign last_bit_s        = (bit_cnt_r == LAST_BIT);
  assign last_gap_s        = (gap_cnt_r == LAST_GAP);

  assign tdm_sync    = sync_r;
  assign tdm_data    = data_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign frame_count = count_r;

  // State register.
  always_ff @(posedge tdm_clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; load_s marks the edge that moves the holding buffer into the shifter.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (hold_full_r) begin
          load_s       = 1'b1;
          next_state_s = SYNC;
        end else begin
          next_state_s = IDLE;
        end
      end
      SYNC: begin
        next_state_s = DATA;
      end
      DATA: begin
        if (!last_bit_s) begin
          next_state_s = DATA;
        end else if (GAP_CYCLES > 0) begin
          next_state_s = GAP;
        end else if (hold_full_r) begin
          load_s       = 1'b1;
          next_state_s = SYNC;
        end else begin
          next_state_s = IDLE;
        end
      end
      GAP: begin
        if (!last_gap_s) begin
          next_state_s = GAP;
        end else if (hold_full_r) begin
          load_s       = 1'b1;
          next_state_s = SYNC;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Buffers, counters and registered outputs; outputs are driven from the next state
  // so they line up with the state they describe.
  always_ff @(posedge tdm_clk) begin
    if (reset) begin
      hold_r      <= '0;
      shift_r     <= '0;
      hold_full_r <= 1'b0;
      bit_cnt_r   <= 7'd0;
      gap_cnt_r   <= 8'd0;
      sync_r      <= 1'b0;
      data_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      count_r     <= 8'd0;
    end else begin
      if (accept_s) begin
        hold_r      <= {frame.ch0[SLOT_BITS-1:0], frame.ch1[SLOT_BITS-1:0],
                        frame.ch2[SLOT_BITS-1:0], frame.ch3[SLOT_BITS-1:0],
                        frame.ch4[SLOT_BITS-1:0]};
        hold_full_r <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end else begin
        hold_full_r <= hold_full_r;
      end

      if (load_s) begin
        shift_r <= hold_r;
      end else if (next_state_s == DATA) begin
        shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
      end else begin
        shift_r <= shift_r;
      end

      if (state_r == DATA) begin
        bit_cnt_r <= last_bit_s ? 7'd0 : bit_cnt_r + 7'd1;
      end else begin
        bit_cnt_r <= 7'd0;
      end

      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + 8'd1;
      end else begin
        gap_cnt_r <= 8'd0;
      end

      sync_r <= (next_state_s == SYNC);
      data_r <= (next_state_s == DATA) ? shift_r[FRAME_BITS-1] : 1'b0;
      busy_r <= (next_state_s != IDLE);
      done_r <= (state_r == DATA) && last_bit_s;
      if ((state_r == DATA) && last_bit_s) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_tdm_serializer.sv
// Bench for tdm_serializer: two instances (GAP_CYCLES 0 and 3) checked every cycle
// against a frame-timeline model, plus hand-computed literal expectations.
module tb_tdm_serializer;

  localparam int SB    = 16;
  localparam int FB    = 5 * SB;
  localparam int GAP_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_serializer_if ifa ();
  tdm_serializer_if ifb ();

  logic [1:0] sync_o, data_o, busy_o, done_o;
  logic [7:0] cnt_a, cnt_b;

  tdm_serializer #(.SLOT_BITS(SB), .GAP_CYCLES(0)) dut_a (
    .tdm_clk(clk), .reset(rst), .frame(ifa),
    .tdm_sync(sync_o[0]), .tdm_data(data_o[0]), .busy(busy_o[0]),
    .frame_done(done_o[0]), .frame_count(cnt_a)
  );

  tdm_serializer #(.SLOT_BITS(SB), .GAP_CYCLES(GAP_B)) dut_b (
    .tdm_clk(clk), .reset(rst), .frame(ifb),
    .tdm_sync(sync_o[1]), .tdm_data(data_o[1]), .busy(busy_o[1]),
    .frame_done(done_o[1]), .frame_count(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a pending frame in the buffer, and the frame on the wire described by
  // the number of cycles since its sync.
  logic [79:0] m_hold [2];
  logic [79:0] m_cur  [2];
  bit          m_hf   [2];
  bit          m_act  [2];
  int          m_t    [2];
  logic [7:0]  m_cnt  [2];
  bit          m_done [2];
  bit          m_acc  [2];
  bit          m_init = 1'b0;

  int          sync_q0 [$];
  int          sync_q1 [$];
  int          done_total [2];
  logic [7:0]  done_log [$];
  logic [15:0] ch0_log [$];
  int          pos0 = 99;
  logic [15:0] cap0 = 16'd0;

  function automatic int gap_of(int k);
    return (k == 0) ? 0 : GAP_B;
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_timeout(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d: timed out waiting", name, cyc);
  endtask

  task automatic get_in(int k, output logic v, output logic [79:0] w);
    if (k == 0) begin
      v = ifa.frame_valid;
      w = {ifa.ch0[15:0], ifa.ch1[15:0], ifa.ch2[15:0], ifa.ch3[15:0], ifa.ch4[15:0]};
    end else begin
      v = ifb.frame_valid;
      w = {ifb.ch0[15:0], ifb.ch1[15:0], ifb.ch2[15:0], ifb.ch3[15:0], ifb.ch4[15:0]};
    end
  endtask

  task automatic step(int k);
    logic v;
    logic [79:0] w;
    bit hf_pre;
    get_in(k, v, w);
    m_acc[k]  = 1'b0;
    m_done[k] = 1'b0;
    if (rst) begin
      m_hf[k] = 1'b0; m_act[k] = 1'b0; m_t[k] = 0; m_cnt[k] = 8'd0;
      m_hold[k] = 80'd0; m_cur[k] = 80'd0;
      m_init = 1'b1;
    end else begin
      hf_pre = m_hf[k];
      if (m_act[k]) begin
        m_t[k]++;
        if (m_t[k] == FB + 1) begin
          m_done[k] = 1'b1;
          m_cnt[k]++;
        end
        if (m_t[k] == FB + 1 + gap_of(k)) m_act[k] = 1'b0;
      end
      if (!m_act[k] && hf_pre) begin
        m_cur[k] = m_hold[k]; m_hf[k] = 1'b0; m_act[k] = 1'b1; m_t[k] = 0;
      end
      if (v && !hf_pre) begin
        m_hold[k] = w; m_hf[k] = 1'b1; m_acc[k] = 1'b1;
      end
    end
  endtask

  task automatic compare(int k);
    logic e_sync, e_data, rdy;
    logic [7:0] cnt;
    e_sync = m_act[k] && (m_t[k] == 0);
    e_data = (m_act[k] && m_t[k] >= 1 && m_t[k] <= FB) ? m_cur[k][FB - m_t[k]] : 1'b0;
    rdy    = (k == 0) ? ifa.frame_ready : ifb.frame_ready;
    cnt    = (k == 0) ? cnt_a : cnt_b;
    chk($sformatf("tdm_sync[%0d]", k),    80'(sync_o[k]), 80'(e_sync));
    chk($sformatf("tdm_data[%0d]", k),    80'(data_o[k]), 80'(e_data));
    chk($sformatf("busy[%0d]", k),        80'(busy_o[k]), 80'(m_act[k]));
    chk($sformatf("frame_done[%0d]", k),  80'(done_o[k]), 80'(m_done[k]));
    chk($sformatf("frame_count[%0d]", k), 80'(cnt),       80'(m_cnt[k]));
    chk($sformatf("frame_ready[%0d]", k), 80'(rdy),       80'(!m_hf[k]));
    if (sync_o[k] === 1'b1) begin
      if (k == 0) sync_q0.push_back(cyc);
      else        sync_q1.push_back(cyc);
    end
    if (done_o[k] === 1'b1) begin
      done_total[k]++;
      if (k == 0) done_log.push_back(cnt_a);
    end
    if (k == 0) begin
      if (sync_o[0] === 1'b1) begin
        pos0 = 0;
      end else if (pos0 < 16) begin
        pos0++;
        cap0 = {cap0[14:0], data_o[0]};
        if (pos0 == 16) ch0_log.push_back(cap0);
      end
    end
  endtask

  // One clock: model advances on the edge, DUT outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    cyc++;
    if (m_init) begin
      compare(0);
      compare(1);
    end
  endtask

  task automatic drive(int k, logic v, logic [31:0] w0, logic [31:0] w1,
                       logic [31:0] w2, logic [31:0] w3, logic [31:0] w4);
    if (k == 0) begin
      ifa.frame_valid = v; ifa.ch0 = w0; ifa.ch1 = w1; ifa.ch2 = w2; ifa.ch3 = w3; ifa.ch4 = w4;
    end else begin
      ifb.frame_valid = v; ifb.ch0 = w0; ifb.ch1 = w1; ifb.ch2 = w2; ifb.ch3 = w3; ifb.ch4 = w4;
    end
  endtask

  task automatic idle_inputs(int k);
    drive(k, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic offer(int k, logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                       logic [31:0] w3, logic [31:0] w4, output int acc_cyc);
    acc_cyc = -1;
    drive(k, 1'b1, w0, w1, w2, w3, w4);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_acc[k]) begin
        acc_cyc = cyc;
        idle_inputs(k);
        return;
      end
    end
    idle_inputs(k);
    fail_timeout("offer");
  endtask

  task automatic wait_sync(int k, output int sc);
    sc = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sync_o[k] === 1'b1) begin
        sc = cyc;
        return;
      end
    end
    fail_timeout("wait_sync");
  endtask

  task automatic wait_idle(int k);
    logic rdy;
    for (int i = 0; i < 1000; i++) begin
      tick();
      rdy = (k == 0) ? ifa.frame_ready : ifb.frame_ready;
      if (busy_o[k] === 1'b0 && rdy === 1'b1) return;
    end
    fail_timeout("wait_idle");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc, sc, base;
    logic [79:0] bits;
    idle_inputs(0);
    idle_inputs(1);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset_ready", 80'(ifa.frame_ready), 80'd1);
    chk("reset_count", 80'(cnt_a), 80'd0);
    chk("reset_busy",  80'(busy_o[0]), 80'd0);
    rst = 1'b0;
    tick();

    // Single frame with upper-bit junk that must not be transmitted.
    offer(0, 32'hDEAD_A5C3, 32'h5555_0001, 32'h0000_8000, 32'h1234_FFFF, 32'hFFFF_1234, acc);
    wait_sync(0, sc);
    chk("latency", 80'(sc - acc), 80'd1);
    bits = 80'd0;
    for (int i = 0; i < FB; i++) begin
      tick();
      bits[FB-1-i] = data_o[0];
    end
    chk("frame_bits", bits, 80'hA5C3_0001_8000_FFFF_1234);
    wait_idle(0);
    chk("count_after_one", 80'(cnt_a), 80'd1);
    chk("ch0_slot", 80'(ch0_log[ch0_log.size()-1]), 80'hA5C3);

    // Back-to-back frames, no gap.
    do_reset();
    sync_q0.delete();
    offer(0, 32'h0000_1111, 32'h2222, 32'h3333, 32'h4444, 32'h5555, acc);
    offer(0, 32'h0000_AAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD, 32'hEEEE, acc);
    tick();
    chk("ready_low_after_b", 80'(ifa.frame_ready), 80'd0);
    wait_idle(0);
    chk("b2b_syncs", 80'(sync_q0.size()), 80'd2);
    if (sync_q0.size() == 2) chk("b2b_period", 80'(sync_q0[1] - sync_q0[0]), 80'd81);
    chk("b2b_count", 80'(cnt_a), 80'd2);

    // Gap of three cycles between queued frames.
    sync_q1.delete();
    offer(1, 32'h0000_F00F, 32'h0F0F, 32'h00FF, 32'hFF00, 32'h8001, acc);
    offer(1, 32'h0000_1357, 32'h2468, 32'h9ACE, 32'hBDF0, 32'h7FFE, acc);
    wait_idle(1);
    chk("gap_syncs", 80'(sync_q1.size()), 80'd2);
    if (sync_q1.size() == 2) chk("gap_period", 80'(sync_q1[1] - sync_q1[0]), 80'd84);

    // Reset during data bit 40.
    do_reset();
    offer(0, 32'h0000_CAFE, 32'hBEEF, 32'h0F0F, 32'hF0F0, 32'h1234, acc);
    wait_sync(0, sc);
    for (int i = 0; i < 41; i++) tick();
    base = done_total[0];
    rst = 1'b1;
    tick();
    chk("rst_mid_sync",  80'(sync_o[0]), 80'd0);
    chk("rst_mid_data",  80'(data_o[0]), 80'd0);
    chk("rst_mid_busy",  80'(busy_o[0]), 80'd0);
    chk("rst_mid_count", 80'(cnt_a), 80'd0);
    chk("rst_mid_ready", 80'(ifa.frame_ready), 80'd1);
    rst = 1'b0;
    tick(); tick();
    chk("rst_mid_no_done", 80'(done_total[0] - base), 80'd0);
    offer(0, 32'h0000_0F1E, 32'h2D3C, 32'h4B5A, 32'h6978, 32'h8796, acc);
    wait_idle(0);
    chk("rst_mid_recover_count", 80'(cnt_a), 80'd1);
    chk("rst_mid_recover_ch0", 80'(ch0_log[ch0_log.size()-1]), 80'h0F1E);

    // frame_valid held high with changing ch0 while the buffer is full.
    do_reset();
    ch0_log.delete();
    for (int i = 0; i < 170; i++) begin
      drive(0, 1'b1, 32'h0000_1000 + 32'(i), 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404);
      tick();
    end
    idle_inputs(0);
    wait_idle(0);
    chk("hold_frames", 80'(ch0_log.size()), 80'd4);
    if (ch0_log.size() == 4) begin
      chk("hold_word0", 80'(ch0_log[0]), 80'h1000);
      chk("hold_word1", 80'(ch0_log[1]), 80'h1002);
      chk("hold_word2", 80'(ch0_log[2]), 80'h1053);
      chk("hold_word3", 80'(ch0_log[3]), 80'h10A4);
    end

    // 257 frames to wrap frame_count.
    do_reset();
    done_log.delete();
    base = done_total[0];
    for (int i = 0; i < 257; i++) begin
      offer(0, 32'(i), ~32'(i), 32'(i * 3), 32'h0000_5A5A, 32'(i + 7), acc);
    end
    wait_idle(0);
    chk("wrap_done_pulses", 80'(done_total[0] - base), 80'd257);
    chk("wrap_final_count", 80'(cnt_a), 80'h01);
    if (done_log.size() == 257) begin
      chk("wrap_count_255", 80'(done_log[254]), 80'hFF);
      chk("wrap_count_256", 80'(done_log[255]), 80'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_serializer.md
TDM_SERIALIZER -- requirements
Module: tdm_serializer

Interface
REQ-001 SLOT_BITS, 16, bits transmitted per channel slot; legal range 1..16.
REQ-002 GAP_CYCLES, 0, minimum idle cycles between the last data bit of a frame and the next sync; legal range 0..255.
REQ-003 tdm_clk  in  1  the only clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ch0..ch4  in  32 each  channel words; only bits [SLOT_BITS-1:0] are transmitted.
REQ-006 frame_valid  in  1  ch0..ch4 hold a frame to send.
REQ-007 frame_ready  out  1  holding buffer empty; a frame is accepted on an edge where frame_valid and frame_ready are both 1.
REQ-008 tdm_sync  out  1  registered frame-start pulse.
REQ-009 tdm_data  out  1  registered serial data, MSB first.
REQ-010 busy  out  1  state is not IDLE.
REQ-011 frame_done  out  1  one-cycle pulse after the last bit of each frame.
REQ-012 frame_count  out  8  count of completed frames; wraps modulo 256.

Function
REQ-013 Frame format: one sync cycle, then 5*SLOT_BITS data cycles.
- Slot order is ch0, ch1, ch2, ch3, ch4.
- Each slot is sent MSB first: bit SLOT_BITS-1 down to bit 0.
- This matches the tdm_deserializer sampling convention.
REQ-014 Buffering: one holding register plus one shift register.
- frame_ready SHALL equal NOT hold_full (combinational from a register).
- An accept captures ch0..ch4 into the holding register and sets hold_full.
REQ-015 The state machine has four states: IDLE, SYNC, DATA, GAP.
REQ-016 IDLE: on an edge with hold_full=1, the holding register transfers to the shift register, hold_full clears and the state becomes SYNC. Otherwise the state stays IDLE.
REQ-017 SYNC: lasts one cycle with tdm_sync=1 and tdm_data=0, then the state becomes DATA with the bit counter at 0.
REQ-018 DATA: in each of 5*SLOT_BITS cycles tdm_sync=0 and tdm_data equals the current bit. On the edge ending the last bit:
- GAP_CYCLES>0: the state becomes GAP.
- GAP_CYCLES=0 and hold_full=1: load the holding register and go to SYNC (back-to-back).
- Otherwise: go to IDLE.
REQ-019 GAP: lasts exactly GAP_CYCLES cycles with tdm_sync=0 and tdm_data=0, then applies the IDLE load rule on its final edge.
REQ-020 Outside SYNC and DATA, tdm_data=0 and tdm_sync=0.
REQ-021 Latency: an accept at edge Ea into an idle block gives tdm_sync=1 in the cycle after edge Ea+1.
REQ-022 Sync period:
- Back-to-back frames with GAP_CYCLES=0: consecutive syncs are exactly 5*SLOT_BITS+1 cycles apart.
- Otherwise: 5*SLOT_BITS+1+GAP_CYCLES cycles apart.
REQ-023 frame_done=1 for the single cycle following the last data bit, and frame_count increments on that same edge (0xFF wraps to 0x00).
REQ-024 Simultaneous load and accept: hold_full clears on the load edge, so frame_ready rises the next cycle. No accept can occur on the load edge itself because frame_ready=0.
REQ-025 frame_valid while frame_ready=0 is ignored: holding register and shift register contents are unchanged, and no error is flagged.
REQ-026 Input words are sampled only on accept; changes to ch0..ch4 after an accept do not affect transmitted data.

Reset
REQ-027 While reset=1 at an edge, the block SHALL go to:
- state IDLE, hold_full=0 (so frame_ready=1 the following cycle);
- tdm_sync=0, tdm_data=0, busy=0, frame_done=0, frame_count=0x00;
- holding and shift registers cleared.
REQ-028 reset takes priority over frame_valid and over any in-progress frame. A partially sent frame is abandoned without frame_done.

Verification
REQ-029 Single frame, SLOT_BITS=16: ch0=0xA5C3, ch1=0x0001, ch2=0x8000, ch3=0xFFFF, ch4=0x1234.
- Expect one sync cycle, then 80 bits 1010_0101_1100_0011 ... 0001_0010_0011_0100.
- Loopback into tdm_deserializer gives ch0..ch4 low halves equal to the inputs and word_ready pulses once.
REQ-030 Back-to-back: frame B is offered while frame A transmits.
- frame_ready=0 from the B accept until the B load.
- Syncs are exactly 81 cycles apart; frame_count reaches 2.
REQ-031 GAP_CYCLES=3, two queued frames: syncs are 84 cycles apart and tdm_data=0 during the 3 gap cycles.
REQ-032 Reset asserted during data bit 40: from the next cycle all outputs read their reset values, there is no frame_done, frame_count=0, and a new frame afterwards transmits correctly.
REQ-033 frame_valid held high with differing ch0 values while frame_ready=0: only the first accepted word and the word accepted after the load are transmitted.
REQ-034 Stream 257 frames: frame_count wraps 0xFF -> 0x00 -> 0x01, and frame_done pulses exactly 257 times.
